// File: rtl/maze_pkg.sv
// Types and constants shared between the maze-solver controller and its path store.
package maze_pkg;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        RIGHT = 2'b01,
        LEFT  = 2'b10,
        DOWN  = 2'b11
    } dir_t;

    localparam int MAZE_DEPTH = 256;
    localparam int DIR_W      = $bits(dir_t);

endpackage

// File: rtl/deque_ram.sv
// Register-array storage for the path deque: one synchronous write port and
// two combinational read ports (back and front).
module deque_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_back,
    input  logic [ADDR_W-1:0] i_raddr_front,
    output logic [DATA_W-1:0] o_rdata_back,
    output logic [DATA_W-1:0] o_rdata_front
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata_back  = r_mem[i_raddr_back];
    assign o_rdata_front = r_mem[i_raddr_front];

endmodule

// File: rtl/path_deque.sv
// Direction-history deque: stack at the back for search/backtrack, FIFO at the
// front for path replay. Popped data and status are registered.
module path_deque
    import maze_pkg::*;
#(
    parameter  int DEPTH  = MAZE_DEPTH,
    parameter  int DATA_W = DIR_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop_back,
    input  logic              pop_front,
    output logic [DATA_W-1:0] back_data,
    output logic              back_valid,
    output logic [DATA_W-1:0] front_data,
    output logic              front_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] r_head, r_tail;
    logic [ADDR_W:0]   r_count;
    logic              r_empty, r_full;
    logic [DATA_W-1:0] r_back_data, r_front_data;
    logic              r_back_valid, r_front_valid;
    logic              r_overflow, r_underflow;

    logic              w_has, w_two;
    logic              w_push_ok, w_pb_ok, w_pf_ok;
    logic              w_refuse_push, w_refuse_pop;
    logic [ADDR_W-1:0] w_tail_m1, w_wr_addr;
    logic [ADDR_W-1:0] w_tail_nxt, w_head_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic [DATA_W-1:0] w_back_rd, w_front_rd;

    // Acceptance is decided entirely on the pre-edge occupancy.
    always_comb begin
        w_has   = (r_count != '0);
        w_two   = (r_count > CNT_ONE);
        w_pb_ok = pop_back && w_has;
        if (push && pop_back)
            w_pf_ok = pop_front && w_has;
        else if (pop_back)
            w_pf_ok = pop_front && w_two;
        else
            w_pf_ok = pop_front && w_has;
        // A same-cycle pop frees the slot, so a push is taken even when full.
        w_push_ok     = push && (!r_full || w_pb_ok || w_pf_ok);
        w_refuse_push = push && !w_push_ok;
        w_refuse_pop  = (pop_back && !w_pb_ok) || (pop_front && !w_pf_ok);
    end

    // push+pop_back overwrites the old back slot instead of moving the tail.
    always_comb begin
        w_tail_m1 = r_tail - PTR_ONE;
        w_wr_addr = w_pb_ok ? w_tail_m1 : r_tail;
        unique case ({w_push_ok, w_pb_ok})
            2'b10:   w_tail_nxt = r_tail + PTR_ONE;
            2'b01:   w_tail_nxt = w_tail_m1;
            default: w_tail_nxt = r_tail;
        endcase
        w_head_nxt = w_pf_ok ? r_head + PTR_ONE : r_head;
        w_cnt_nxt  = r_count + {{ADDR_W{1'b0}}, w_push_ok}
                             - {{ADDR_W{1'b0}}, w_pb_ok}
                             - {{ADDR_W{1'b0}}, w_pf_ok};
    end

    deque_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .Clk           (Clk),
        .i_we          (w_push_ok),
        .i_waddr       (w_wr_addr),
        .i_wdata       (din),
        .i_raddr_back  (w_tail_m1),
        .i_raddr_front (r_head),
        .o_rdata_back  (w_back_rd),
        .o_rdata_front (w_front_rd)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_back_data   <= '0;
            r_back_valid  <= 1'b0;
            r_front_data  <= '0;
            r_front_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else if (clr) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_back_data   <= '0;
            r_back_valid  <= 1'b0;
            r_front_data  <= '0;
            r_front_valid <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_head        <= w_head_nxt;
            r_tail        <= w_tail_nxt;
            r_count       <= w_cnt_nxt;
            r_empty       <= (w_cnt_nxt == '0);
            r_full        <= (w_cnt_nxt == CNT_FULL);
            r_back_valid  <= w_pb_ok;
            r_front_valid <= w_pf_ok;
            if (w_pb_ok)
                r_back_data <= w_back_rd;
            if (w_pf_ok)
                r_front_data <= w_front_rd;
            if (w_refuse_push)
                r_overflow <= 1'b1;
            if (w_refuse_pop)
                r_underflow <= 1'b1;
        end
    end

    assign back_data   = r_back_data;
    assign back_valid  = r_back_valid;
    assign front_data  = r_front_data;
    assign front_valid = r_front_valid;
    assign empty       = r_empty;
    assign full        = r_full;
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_path_deque.sv
// Directed bench for path_deque: per-cycle vector table plus full/wrap sequence.
module tb_path_deque;
    import maze_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst, clr, push, pop_back, pop_front;
    logic [1:0] din;
    logic [1:0] back_data, front_data;
    logic       back_valid, front_valid, empty, full, overflow, underflow;
    logic [8:0] count;

    int n_chk  = 0;
    int n_fail = 0;

    path_deque dut (
        .Clk(Clk), .Rst(Rst), .clr(clr), .push(push), .din(din),
        .pop_back(pop_back), .pop_front(pop_front),
        .back_data(back_data), .back_valid(back_valid),
        .front_data(front_data), .front_valid(front_valid),
        .empty(empty), .full(full), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       c, p;
        logic [1:0] d;
        logic       pb, pf;
        logic [1:0] bd;
        logic       bv;
        logic [1:0] fd;
        logic       fv, em, fu;
        int         cnt;
        logic       ov, un;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic c, p, input logic [1:0] d, input logic pb, pf,
                       input logic [1:0] bd, input logic bv, input logic [1:0] fd,
                       input logic fv, em, fu, input int cnt, input logic ov, un);
        vec_t v;
        v.c = c; v.p = p; v.d = d; v.pb = pb; v.pf = pf;
        v.bd = bd; v.bv = bv; v.fd = fd; v.fv = fv; v.em = em; v.fu = fu;
        v.cnt = cnt; v.ov = ov; v.un = un;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic c, p, input logic [1:0] d, input logic pb, pf);
        @(negedge Clk);
        clr = c; push = p; din = d; pop_back = pb; pop_front = pf;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [1:0] val(input int k);
        logic [31:0] kk;
        kk = k;
        return kk[1:0] ^ kk[3:2];
    endfunction

    initial begin
        Rst = 1'b1; clr = 1'b0; push = 1'b0; din = 2'b00;
        pop_back = 1'b0; pop_front = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst.count", int'(count), 0);
        chk("rst.empty", int'(empty), 1);
        chk("rst.full",  int'(full), 0);
        chk("rst.bv",    int'(back_valid), 0);
        chk("rst.flags", int'({overflow, underflow}), 0);
        @(negedge Clk);
        Rst = 1'b0;

        //   c p d  pb pf   bd bv fd fv em fu cnt ov un
        add(1,1,3, 0,0,   0,0, 0,0, 1,0, 0, 0,0); // clr beats push
        add(0,1,0, 0,0,   0,0, 0,0, 0,0, 1, 0,0);
        add(0,1,1, 0,0,   0,0, 0,0, 0,0, 2, 0,0);
        add(0,1,2, 0,0,   0,0, 0,0, 0,0, 3, 0,0);
        add(0,1,3, 0,0,   0,0, 0,0, 0,0, 4, 0,0);
        add(0,0,0, 1,0,   3,1, 0,0, 0,0, 3, 0,0); // stack order
        add(0,0,0, 1,0,   2,1, 0,0, 0,0, 2, 0,0);
        add(0,0,0, 1,0,   1,1, 0,0, 0,0, 1, 0,0);
        add(0,0,0, 1,0,   0,1, 0,0, 1,0, 0, 0,0);
        add(0,0,0, 0,0,   0,0, 0,0, 1,0, 0, 0,0);
        add(0,1,1, 0,0,   0,0, 0,0, 0,0, 1, 0,0); // FIFO replay
        add(0,1,1, 0,0,   0,0, 0,0, 0,0, 2, 0,0);
        add(0,1,3, 0,0,   0,0, 0,0, 0,0, 3, 0,0);
        add(0,1,2, 0,0,   0,0, 0,0, 0,0, 4, 0,0);
        add(0,0,0, 0,1,   0,0, 1,1, 0,0, 3, 0,0);
        add(0,0,0, 0,1,   0,0, 1,1, 0,0, 2, 0,0);
        add(0,0,0, 0,1,   0,0, 3,1, 0,0, 1, 0,0);
        add(0,0,0, 0,1,   0,0, 2,1, 1,0, 0, 0,0);
        add(0,0,0, 0,1,   0,0, 2,0, 1,0, 0, 0,1); // underflow
        add(1,0,0, 0,0,   0,0, 0,0, 1,0, 0, 0,0);
        add(0,1,0, 0,0,   0,0, 0,0, 0,0, 1, 0,0); // push+pop_back swap
        add(0,1,1, 0,0,   0,0, 0,0, 0,0, 2, 0,0);
        add(0,1,2, 0,0,   0,0, 0,0, 0,0, 3, 0,0);
        add(0,1,3, 1,0,   2,1, 0,0, 0,0, 3, 0,0);
        add(0,0,0, 1,0,   3,1, 0,0, 0,0, 2, 0,0);
        add(1,0,0, 0,0,   0,0, 0,0, 1,0, 0, 0,0); // conflict at count==1
        add(0,1,1, 0,0,   0,0, 0,0, 0,0, 1, 0,0);
        add(0,0,0, 1,1,   1,1, 0,0, 1,0, 0, 0,1);
        add(1,0,0, 0,0,   0,0, 0,0, 1,0, 0, 0,0); // push+pop on empty
        add(0,1,2, 1,0,   0,0, 0,0, 0,0, 1, 0,1);
        add(0,1,1, 0,1,   0,0, 2,1, 0,0, 1, 0,1);
        add(0,0,0, 0,1,   0,0, 1,1, 1,0, 0, 0,1);
        add(1,0,0, 0,0,   0,0, 0,0, 1,0, 0, 0,0); // all three strobes
        add(0,1,0, 0,0,   0,0, 0,0, 0,0, 1, 0,0);
        add(0,1,3, 0,0,   0,0, 0,0, 0,0, 2, 0,0);
        add(0,1,1, 1,1,   3,1, 0,1, 0,0, 1, 0,0);
        add(0,0,0, 1,0,   1,1, 0,0, 1,0, 0, 0,0);

        foreach (vt[i]) begin
            step(vt[i].c, vt[i].p, vt[i].d, vt[i].pb, vt[i].pf);
            chk($sformatf("v%0d.bd", i),  int'(back_data),   int'(vt[i].bd));
            chk($sformatf("v%0d.bv", i),  int'(back_valid),  int'(vt[i].bv));
            chk($sformatf("v%0d.fd", i),  int'(front_data),  int'(vt[i].fd));
            chk($sformatf("v%0d.fv", i),  int'(front_valid), int'(vt[i].fv));
            chk($sformatf("v%0d.em", i),  int'(empty),       int'(vt[i].em));
            chk($sformatf("v%0d.fu", i),  int'(full),        int'(vt[i].fu));
            chk($sformatf("v%0d.cnt", i), int'(count),       vt[i].cnt);
            chk($sformatf("v%0d.ov", i),  int'(overflow),    int'(vt[i].ov));
            chk($sformatf("v%0d.un", i),  int'(underflow),   int'(vt[i].un));
        end

        // Fill to capacity; entry k always holds val(k).
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 256; k++) begin
            step(0, 1, val(k), 0, 0);
            if (k == 254) chk("fill.notfull", int'(full), 0);
        end
        chk("fill.full",  int'(full), 1);
        chk("fill.count", int'(count), 256);
        chk("fill.ov0",   int'(overflow), 0);
        step(0, 1, 2'b11, 0, 0);
        chk("ovf.flag",  int'(overflow), 1);
        chk("ovf.count", int'(count), 256);

        for (int k = 0; k < 200; k++) begin
            step(0, 0, 0, 0, 1);
            chk($sformatf("drain%0d", k), int'(front_data), int'(val(k)));
        end
        chk("drain.count", int'(count), 56);
        for (int k = 256; k < 456; k++)
            step(0, 1, val(k), 0, 0);
        chk("wrap.count", int'(count), 256);
        chk("wrap.full",  int'(full), 1);

        // push+pop_front while full keeps occupancy at capacity.
        step(0, 1, val(456), 0, 1);
        chk("fullpp.fd",    int'(front_data), int'(val(200)));
        chk("fullpp.count", int'(count), 256);
        chk("fullpp.ov",    int'(overflow), 1);

        for (int k = 201; k <= 456; k++) begin
            step(0, 0, 0, 0, 1);
            chk($sformatf("wrap%0d", k), int'(front_data), int'(val(k)));
        end
        chk("end.empty", int'(empty), 1);
        chk("end.count", int'(count), 0);
        chk("end.un",    int'(underflow), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/path_deque.md
Name: path_deque

Overview:
- Direction-history store serving the maze-solver controller.
- Responds to the controller's `push`, `pop_back` and `pop_front` strobes.
- Used as a stack (push/pop_back) during search and backtracking, and as a FIFO (pop_front) during path replay.
- Returns popped direction codes and the empty/full status the controller branches on.

Parameters:
- `DEPTH`, 256, number of entries; power of two; sized for a 16x16 maze.
- `DATA_W`, 2, direction code width.
- `ADDR_W`, `$clog2(DEPTH)`, pointer width (derived; not overridden).

Ports:
- `Clk`  in  1  clock.
- `Rst`  in  1  asynchronous active-high reset.
- `clr`  in  1  synchronous clear, driven by the controller's `our_reset`.
- `push`  in  1  append `din` at back.
- `din`  in  `DATA_W`  direction to push (`dir`).
- `pop_back`  in  1  remove back entry.
- `pop_front`  in  1  remove front entry.
- `back_data`  out  `DATA_W`  value removed by last accepted `pop_back` (`stack_out`).
- `back_valid`  out  1  pulse: `back_data` updated this cycle.
- `front_data`  out  `DATA_W`  value removed by last accepted `pop_front`.
- `front_valid`  out  1  pulse: `front_data` updated this cycle.
- `empty`  out  1  count==0 (`is_deque_empty`).
- `full`  out  1  count==`DEPTH`.
- `count`  out  `ADDR_W+1`  current occupancy.
- `overflow`  out  1  sticky: push refused while full.
- `underflow`  out  1  sticky: pop refused while empty.

Behaviour:
- Storage is a circular buffer.
  - `head` points at the front entry; `tail` points one past the back entry.
  - All pointer arithmetic wraps modulo `DEPTH`.
- Reset (`Rst` async, or `clr` sync, same effect):
  - `head`=`tail`=0, `count`=0, `empty`=1, `full`=0.
  - `back_data`=`front_data`=0, `back_valid`=`front_valid`=0, `overflow`=`underflow`=0.
  - Storage contents are don't-care.
  - `clr` has priority over all strobes in the same cycle.
- Push, accepted when not full:
  - `mem[tail]` <= `din`; `tail` <= `tail`+1; `count`+1.
- `pop_back`, accepted when not empty:
  - `back_data` <= `mem[tail-1]`; `tail` <= `tail`-1; `count`-1.
  - `back_valid`=1 in the following cycle only.
- `pop_front`, accepted when not empty:
  - `front_data` <= `mem[head]`; `head` <= `head`+1; `count`-1.
  - `front_valid`=1 in the following cycle only.
- Latency: popped data is registered and visible one cycle after the strobe. This matches the controller's Backtracking -> Pop_stack sequence.
- `empty`, `full` and `count` are registered and reflect all operations of the previous edge.
- Simultaneous events, evaluated on the state before the edge:
  - `push`+`pop_back`, count>0: `back_data` <= old back; new `din` written at `tail-1`; `tail` and `count` unchanged.
  - `push`+`pop_back`, empty: push accepted; `pop_back` refused; `underflow` set.
  - `push`+`pop_front`, count>0: both accepted; `count` unchanged. This holds even when full.
  - `push`+`pop_front`, empty: push accepted; `pop_front` refused; `underflow` set.
  - `pop_back`+`pop_front`, count>=2: both accepted; `count`-2.
  - `pop_back`+`pop_front`, count==1: `pop_back` wins; `pop_front` refused; `underflow` set.
  - All three strobes: the push+`pop_back` rule applies, then `pop_front` is accepted if count>0 before the edge.
- Refused push: no state change except `overflow`<=1.
- Refused pop: no state change except `underflow`<=1; the corresponding `*_valid` stays 0.
- `overflow`/`underflow` clear only on `Rst`/`clr`.
- Wrap-around: after `DEPTH` pushes and pops at either end, pointer wrap must be seamless; `full`/`empty` are derived from `count`, not from pointer equality.

Decomposition:
- Package `maze_pkg`:
  - `dir_t` enum: `UP`=2'b00, `RIGHT`=2'b01, `LEFT`=2'b10, `DOWN`=2'b11.
  - `MAZE_DEPTH`=256 constant, shared with the controller.
- Sub-module `deque_ram`:
  - `DEPTH`x`DATA_W` register array.
  - One synchronous write port; two asynchronous read ports (back at `tail-1`, front at `head`).
  - Pointer, count and flag logic stays in `path_deque`.

Test Plan:
- Reset/clear: `clr` asserted with `push`=1 for one cycle -> `count`=0, `empty`=1, nothing stored.
- Stack order: push 00,01,10,11, then `pop_back` x4 -> `back_data` 11,10,01,00, each with `back_valid` one cycle after its strobe; `empty`=1 at the end.
- FIFO replay: push 01,01,11,10, then `pop_front` every cycle -> `front_data` 01,01,11,10; `empty`=1 one cycle after the 4th pop; further `pop_front` -> `underflow`=1, `front_valid`=0.
- Full/wrap:
  - Push 256 entries -> `full`=1, `count`=256; a 257th push -> `overflow`=1, `count` stays 256.
  - Then `pop_front` x200 and push x200 -> `count`=256; `pop_front` order continues seamlessly across the wrap.
- Simultaneous: with 3 entries (00,01,10), assert `push`(11)+`pop_back` -> `back_data`=10, `count`=3; then `pop_back` -> 11.
- Conflict: with 1 entry (01), assert `pop_back`+`pop_front` -> `back_data`=01, `back_valid`=1, `front_valid`=0, `underflow`=1, `empty`=1.
